blink_code_arbiter: RTL and testbench

Shares the board LEDs between NREQ requesters. Each requester asks to flash a 4-bit status code as a burst of blinks on led0. The block grants requesters round-robin, times the on, off and gap phases from a prescaled tick, and acknowledges completion. It sits in the sysClk (100 MHz PLL/BUFG) domain next to the board-level LED logic. led1 shows busy.

---
 rtl/blink_pkg.sv | 24 ++
 rtl/blink_code_arbiter_tick_gen.sv | 29 ++
 rtl/blink_code_arbiter.sv | 171 +++++++++++++++++
 tb/tb_blink_code_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink-code LED arbiter.
// Holds the sequencer state encoding, code width and counter sizing.
package blink_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ON,
    OFF,
    GAP,
    DONE
  } state_t;

  localparam int CODE_W = 4;

  // Bits needed for a phase counter that counts 0..max(a,b,c)-1.
  function automatic int phase_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/blink_code_arbiter_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_DIV sysClk cycles.
// Ports: sysClk, rst (sync, active high), clr (restart count), tick.
module tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic sysClk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge sysClk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/blink_code_arbiter.sv
// Round-robin arbiter that lets NREQ requesters flash a 4-bit code on led0.
// Ports: sysClk, rst, req/code in; grant, ack, led0 (blink), led1 (busy) out.
module blink_code_arbiter
  import blink_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TICK_DIV  = 10_000_000,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 3,
  parameter int GAP_TICKS = 10
) (
  input  logic                   sysClk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*CODE_W-1:0] code,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        ack,
  output logic                   led0,
  output logic                   led1
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = phase_w(ON_TICKS, OFF_TICKS, GAP_TICKS);

  state_t            state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  logic [CODE_W-1:0] rem_q, rem_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              led0_q, led0_d;
  logic              led1_q, led1_d;

  logic          clr;
  logic          tick;
  logic          ph_last;
  logic [IW-1:0] pick;

  // First requester at or after last+1, wrapping.
  function automatic logic [IW-1:0] rr_pick(
    input logic [NREQ-1:0] r,
    input logic [IW-1:0]   last
  );
    logic found;
    int   idx;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && r[idx]) begin
        rr_pick = IW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .sysClk(sysClk),
    .rst   (rst),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    grant_d = grant_q;
    ack_d   = '0;
    led0_d  = led0_q;
    clr     = 1'b0;
    pick    = rr_pick(req, win_q);
    ph_last = (state_q == ON)  ? (phase_q == PW'(ON_TICKS - 1)) :
              (state_q == OFF) ? (phase_q == PW'(OFF_TICKS - 1)) :
                                 (phase_q == PW'(GAP_TICKS - 1));

    unique case (state_q)
      IDLE: begin
        clr     = 1'b1;
        phase_d = '0;
        if (|req) begin
          win_d   = pick;
          grant_d = NREQ'(1) << pick;
          rem_d   = code[CODE_W*pick +: CODE_W];
          if (rem_d != '0) begin
            state_d = ON;
            led0_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      ON, OFF, GAP: begin
        if (!req[win_q]) begin
          // Requester withdrew: drop everything, no ack.
          state_d = IDLE;
          led0_d  = 1'b0;
          grant_d = '0;
          clr     = 1'b1;
          phase_d = '0;
        end else if (tick) begin
          if (ph_last) begin
            clr     = 1'b1;
            phase_d = '0;
            if (state_q == ON) begin
              state_d = OFF;
              led0_d  = 1'b0;
            end else if (state_q == OFF) begin
              rem_d = rem_q - 1'b1;
              if (rem_q > 4'd1) begin
                state_d = ON;
                led0_d  = 1'b1;
              end else begin
                state_d = GAP;
              end
            end else begin
              state_d = DONE;
              ack_d   = grant_q;
              grant_d = '0;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      DONE: begin
        // A zero code arrives here still granted; ack it on this pass.
        if (|grant_q) begin
          ack_d   = grant_q;
          grant_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    led1_d = (state_d != IDLE);
  end

  always_ff @(posedge sysClk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= IW'(NREQ - 1);
      rem_q   <= '0;
      phase_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      led0_q  <= 1'b0;
      led1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      led0_q  <= led0_d;
      led1_q  <= led1_d;
    end
  end

  assign grant = grant_q;
  assign ack   = ack_q;
  assign led0  = led0_q;
  assign led1  = led1_q;

endmodule

// File: tb/tb_blink_code_arbiter.sv
// Directed bench for blink_code_arbiter.
// Checks {led0,led1,grant,ack} every cycle against hand-derived timing.
module tb_blink_code_arbiter;

  localparam int NREQ = 4;
  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 2;
  localparam int GAPT = 3;

  logic        sysClk = 1'b0;
  logic        rst    = 1'b1;
  logic [3:0]  req    = '0;
  logic [15:0] code   = '0;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        led0;
  logic        led1;
  logic [9:0]  obs;
  logic [9:0]  exp_v;

  int checks = 0;
  int errors = 0;

  blink_code_arbiter #(
    .NREQ     (NREQ),
    .TICK_DIV (TD),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT)
  ) dut (
    .sysClk(sysClk),
    .rst   (rst),
    .req   (req),
    .code  (code),
    .grant (grant),
    .ack   (ack),
    .led0  (led0),
    .led1  (led1)
  );

  always #5 sysClk = ~sysClk;

  assign obs = {led0, led1, grant, ack};

  task automatic step();
    @(posedge sysClk);
    @(negedge sysClk);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expected outputs o cycles after grant for a sequence with code n.
  function automatic logic [9:0] seq_exp(
    input int n, input int o, input logic [3:0] g
  );
    int  gl;
    logic l0;
    gl = (n * (ONT + OFFT) + GAPT) * TD;
    l0 = (o < n * (ONT + OFFT) * TD) &&
         ((o % ((ONT + OFFT) * TD)) < ONT * TD);
    return {l0, (o <= gl),
            (o < gl) ? g : 4'b0000,
            (o == gl) ? g : 4'b0000};
  endfunction

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'hf;
    code = 16'h3333;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs !== 10'b0) begin
        errors++;
        $display("FAIL reset k=%0d got=%b want=%b", k, obs, 10'b0);
      end
    end
    req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    code = 16'h0003;
    req  = 4'b0001;
    for (int k = 1; k <= 62; k++) begin
      step();
      exp_v = seq_exp(3, k - 1, 4'b0001);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 61) req = '0;
    end
  endtask

  task automatic test_zero_code();
    logic [9:0] e [3];
    e[0] = {1'b0, 1'b1, 4'b0100, 4'b0000};
    e[1] = {1'b0, 1'b1, 4'b0000, 4'b0100};
    e[2] = 10'b0;
    do_reset();
    code = 16'h0000;
    req  = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (obs !== e[k-1]) begin
        errors++;
        $display("FAIL zero_code k=%0d got=%b want=%b", k, obs, e[k-1]);
      end
      if (k == 2) req = '0;
    end
  endtask

  task automatic test_round_robin();
    int order [6];
    int j;
    int o;
    order = '{0, 1, 3, 0, 1, 3};
    do_reset();
    code = 16'h1011;
    req  = 4'b1011;
    for (int k = 1; k <= 180; k++) begin
      step();
      j = (k - 1) / 30;
      o = (k - 1) % 30;
      exp_v = seq_exp(1, o, 4'(1 << order[j]));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL round_robin k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (o == 28) req[order[j]] = 1'b0;
      if (o == 29) req[order[j]] = 1'b1;
    end
    req = '0;
  endtask

  task automatic test_abort();
    do_reset();
    code = 16'h0150;
    req  = 4'b0010;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k <= 20)      exp_v = seq_exp(5, k - 1, 4'b0010);
      else if (k == 21) exp_v = 10'b0;
      else              exp_v = {1'b1, 1'b1, 4'b0100, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 3)  req[2] = 1'b1;
      if (k == 20) req[1] = 1'b0;
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    code = 16'h0003;
    req  = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k <= 10)      exp_v = seq_exp(3, k - 1, 4'b0001);
      else if (k == 11) exp_v = 10'b0;
      else              exp_v = {1'b1, 1'b1, 4'b0001, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 2)  req[1] = 1'b1;
      if (k == 10) rst = 1'b1;
      if (k == 11) rst = 1'b0;
    end
    req = '0;
  endtask

  task automatic test_code_change();
    do_reset();
    code = 16'h0002;
    req  = 4'b0001;
    for (int k = 1; k <= 46; k++) begin
      step();
      exp_v = seq_exp(2, k - 1, 4'b0001);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL code_change k=%0d got=%b want=%b", k, obs, exp_v);
      end
      if (k == 5)  code = 16'h0007;
      if (k == 45) req = '0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_code();
    test_round_robin();
    test_abort();
    test_reset_mid();
    test_code_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
